alu_mul_seq: RTL and testbench

//  Multi-cycle unsigned multiplier sequencer that borrows the shared 32-bit ALU.
//  It runs 32 shift-add iterations, issuing an ADD on the ALU each granted cycle.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mul_seq.sv | 116 +++++++++++
 tb/tb_alu_mul_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings and multiplier sequencer states.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier that borrows the shared ALU adder,
// one iteration per granted cycle, 64-bit product on {prod_hi, prod_lo}.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_prod_hi;
    logic [WIDTH-1:0] r_prod_lo;

    logic             w_in_iter;
    logic             w_zero_op;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic             w_unused_zero;

    assign w_in_iter = (r_state == ST_ITER);
    assign w_zero_op = EARLY_ZERO && ((op_a == '0) || (op_b == '0));
    // The ALU only returns WIDTH bits; the lost carry-out is recovered by
    // noticing the unsigned sum wrapped below its addend.
    assign w_carry   = (alu_result < alu_a);
    assign w_next_hi = {w_carry, alu_result[WIDTH-1:1]};
    assign w_next_lo = {alu_result[0], r_lo[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // The zero flag is reserved for future use and intentionally ignored.
    assign w_unused_zero = alu_zero;

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign prod_hi  = r_prod_hi;
    assign prod_lo  = r_prod_lo;
    assign alu_req  = w_in_iter;
    assign alu_a    = w_in_iter ? r_hi : '0;
    assign alu_b    = (w_in_iter && r_lo[0]) ? r_mcand : '0;
    assign alu_ctrl = w_in_iter ? ALU_ADD : ALU_AND;

    // FSM, iteration counter and {hi,lo} shift register; product latched on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= op_a;
                        r_hi    <= '0;
                        r_lo    <= op_b;
                        r_cnt   <= '0;
                        if (w_zero_op) begin
                            r_prod_hi <= '0;
                            r_prod_lo <= '0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (alu_gnt) begin
                        r_hi <= w_next_hi;
                        r_lo <= w_next_lo;
                        if (w_last) begin
                            r_prod_hi <= w_next_hi;
                            r_prod_lo <= w_next_lo;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU wired to alu_*.
module tb_alu_mul_seq;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] prod;
        int          acc;
        int          lmin;
        int          lmax;
        int          n_iter;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    exp_t q[$];
    int   cyc;
    int   gmode;
    int   n_cmp;
    int   n_bad;
    int   reqc;
    int   gntc;

    alu_mul_seq #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .prod_hi    (prod_hi),
        .prod_lo    (prod_lo),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Shared combinational ALU
    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = {31'd0, (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Grant pattern: 0 = always, 1 = toggling, else random
    initial begin
        alu_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (gmode)
                0:       alu_gnt = 1'b1;
                1:       alu_gnt = ~alu_gnt;
                default: alu_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
        end
    endtask

    // Monitor: interface sanity every cycle, scoreboard pop on done
    always @(negedge clk) begin
        if (!rst_n) begin
            reqc = 0;
            gntc = 0;
        end else begin
            if (alu_req) begin
                reqc++;
                if (alu_gnt) gntc++;
                chk("alu_ctrl_iter", 64'(alu_ctrl), 64'(ALU_ADD));
            end else begin
                chk("alu_ctrl_idle", 64'(alu_ctrl), 64'(ALU_AND));
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("prod_hi", 64'(prod_hi), 64'(e.prod[63:32]));
                    chk("prod_lo", 64'(prod_lo), 64'(e.prod[31:0]));
                    chk_range("latency", cyc - e.acc, e.lmin, e.lmax);
                    chk("granted_iters", 64'(gntc), 64'(e.n_iter));
                    if (e.n_iter == 0) chk("req_on_zero", 64'(reqc), 64'd0);
                end
                reqc = 0;
                gntc = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int gm,
                         input int lmin, input int lmax);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while ((busy || done) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (busy || done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: got busy=%0b done=%0b expected idle", busy, done);
        end else begin
            gmode    = gm;
            e.prod   = 64'(a) * 64'(b);
            e.acc    = cyc;
            e.n_iter = (a == 0 || b == 0) ? 0 : 32;
            e.lmin   = (e.n_iter == 0) ? 1 : lmin;
            e.lmax   = (e.n_iter == 0) ? 1 : lmax;
            q.push_back(e);
            op_a  = a;
            op_b  = b;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d ops pending expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        gmode = 0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("rst_alu_req", 64'(alu_req), 64'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALU_AND));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1) basic product, 5) start while busy must be ignored
        issue(32'hA, 32'h7, 0, 33, 33);
        chk("busy_after_accept", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        op_a  = 32'h5;
        op_b  = 32'h9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("prod_hold", {prod_hi, prod_lo}, 64'd70);
        chk("idle_busy", 64'(busy), 64'd0);

        // 2) carry path
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 33);
        drain();

        // 3) early zero
        issue(32'h0, 32'h1234, 0, 1, 1);
        drain();
        issue(32'h55, 32'h0, 0, 1, 1);
        drain();

        // 4) toggling grant
        issue(32'h10000, 32'h10000, 1, 64, 65);
        drain();

        // 6) reset mid-iteration aborts
        issue(32'd123, 32'd456, 0, 33, 33);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        chk("abort_alu_req", 64'(alu_req), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd123, 32'd456, 0, 33, 33);
        drain();

        // Randomized operands and grant patterns, issued back to back
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = '0;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
            issue(a, b, (i % 3 == 0) ? 0 : 2, 33, 300);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
